// File: rtl/imoy_calc.sv
`default_nettype none
// ============================================================================
// Module   : imoy_calc
// Purpose  : Streaming 3x3 box mean (x455>>12) over raster luma, 3-cycle latency.
//            Optional macro IMOY_ROUND_EN adds round-to-nearest before the shift.
// Revision : 1.0
// ============================================================================
module imoy_calc #(
  parameter int DW_IN = 10,
  parameter int IMG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_vld,
  input  logic             pix_sof,
  input  logic [DW_IN-1:0] pix,
  output logic             imoy_vld,
  output logic [DW_IN-1:0] imoy
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW   = DW_IN + 2;
  localparam int SUMW = DW_IN + 4;
  localparam int PW   = DW_IN + 13;
  localparam int RW   = PW + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [PW-1:0] RECIP    = PW'(455);
  localparam logic [RW-1:0] MAXV     = RW'((1 << DW_IN) - 1);

  logic [CW-1:0]    col, cur_col;
  logic [1:0]       row, cur_row;
  logic             win;
  logic [DW_IN-1:0] lb1 [IMG_W];
  logic [DW_IN-1:0] lb0 [IMG_W];
  logic [DW_IN-1:0] lb1_rd, lb0_rd;
  logic [SW-1:0]    colsum, cs0, cs1, cs2;
  logic             s1_vld, s2_vld;
  logic [SUMW-1:0]  sum9;
  logic [PW-1:0]    prod;
  logic [RW-1:0]    prod_r, mean_full;
  logic [DW_IN-1:0] mean_clamped;

  // SOF takes effect on the very pixel that carries it
  always_comb begin
    cur_col = pix_sof ? '0 : col;
    cur_row = pix_sof ? '0 : row;
    win     = pix_vld && (cur_row == 2'd2) && (cur_col >= CW'(2));
    lb1_rd  = lb1[cur_col];
    lb0_rd  = lb0[cur_col];
    colsum  = SW'(pix) + SW'(lb1_rd) + SW'(lb0_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_vld) begin
      if (cur_col == LAST_COL) begin
        col <= '0;
        row <= (cur_row == 2'd2) ? cur_row : cur_row + 2'd1;
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Read-before-write: lb0 takes the value lb1 held before this pixel
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      lb1[cur_col] <= pix;
      lb0[cur_col] <= lb1[cur_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs0    <= '0;
      cs1    <= '0;
      cs2    <= '0;
      s1_vld <= 1'b0;
      sum9   <= '0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= win;
      if (pix_vld) begin
        cs0 <= colsum;
        cs1 <= cs0;
        cs2 <= cs1;
      end
      sum9   <= SUMW'(cs0) + SUMW'(cs1) + SUMW'(cs2);
      s2_vld <= s1_vld;
    end
  end

  always_comb begin
    prod = PW'(sum9) * RECIP;
`ifdef IMOY_ROUND_EN
    prod_r = RW'(prod) + RW'(2048);
`else
    prod_r = RW'(prod);
`endif
    mean_full    = prod_r >> 12;
    mean_clamped = (mean_full > MAXV) ? MAXV[DW_IN-1:0] : mean_full[DW_IN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imoy_vld <= 1'b0;
      imoy     <= '0;
    end else begin
      imoy_vld <= s2_vld;
      if (s2_vld) imoy <= mean_clamped;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imoy_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_imoy_calc
// Purpose  : Scoreboard bench for imoy_calc (IMG_W=8), directed frames.
// Revision : 1.0
// ============================================================================
module tb_imoy_calc;
  localparam int DW = 10;
  localparam int W  = 8;
`ifdef IMOY_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_vld = 1'b0;
  logic          pix_sof = 1'b0;
  logic [DW-1:0] pix = '0;
  logic          imoy_vld;
  logic [DW-1:0] imoy;

  imoy_calc #(.DW_IN(DW), .IMG_W(W)) dut (
    .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix(pix),
    .imoy_vld(imoy_vld), .imoy(imoy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int nout  = 0;
  int mode  = 0;
  int mrow  = 0;
  int mcol  = 0;
  int img [16][W];
  int exp_q [$];
  int due_q [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mean9(input int s);
    int p;
    p = s * 455;
    if (RND != 0) p = p + 2048;
    p = p >>> 12;
    if (p > 1023) p = 1023;
    return p;
  endfunction

  function automatic int pat(input int r, input int c);
    case (mode)
      1: return 1023;
      2: return c * 10;
      3: return (r == 2 && c == 3) ? 900 : 0;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  // Expected value: hand-derived constants for directed modes, 3x3 model otherwise
  function automatic int expect_at(input int r, input int c);
    int s;
    case (mode)
      1: return (RND != 0) ? 1023 : 1022;
      2: return 10 * (c - 1) - ((RND != 0) ? 0 : 1);
      3: return (r - 1 >= 1 && r - 1 <= 3 && c - 1 >= 2 && c - 1 <= 4)
                ? ((RND != 0) ? 100 : 99) : 0;
      default: begin
        s = 0;
        for (int i = r - 2; i <= r; i++)
          for (int j = c - 2; j <= c; j++) s += img[i][j];
        return mean9(s);
      end
    endcase
  endfunction

  task automatic send(input logic sof, input int val);
    if (sof) begin mrow = 0; mcol = 0; end
    img[mrow][mcol] = val;
    pix_vld = 1'b1;
    pix_sof = sof;
    pix     = val[DW-1:0];
    if (mrow >= 2 && mcol >= 2) begin
      exp_q.push_back(expect_at(mrow, mcol));
      due_q.push_back(cyc + 3);
    end
    mcol++;
    if (mcol == W) begin mcol = 0; mrow++; end
    @(posedge clk); #1;
    pix_vld = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic frame_px(input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      send(i == 0, pat(i / W, i % W));
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete(); due_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (imoy_vld) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got imoy=%0d expected no output", imoy);
      end else begin
        check("imoy_val", int'(imoy), exp_q.pop_front());
        check("imoy_lat", cyc, due_q.pop_front());
        nout++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", int'(imoy_vld), 0);
    check("rst_imoy", int'(imoy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    mode = 1; nout = 0; frame_px(5 * W, 0); drain(); check("flat_count", nout, 18);
    mode = 2; nout = 0; frame_px(5 * W, 0); drain(); check("ramp_count", nout, 18);
    mode = 3; nout = 0; frame_px(5 * W, 0); drain(); check("impulse_count", nout, 18);
    mode = 0; nout = 0; frame_px(5 * W, 1); drain(); check("gap_count", nout, 18);

    // SOF at row 3 col 4: 6 + 2 old-frame outputs, then a full new frame
    nout = 0;
    frame_px(3 * W + 4, 0);
    frame_px(5 * W, 1);
    drain();
    check("sof_count", nout, 26);

    // Reset pulse with outputs in flight: only results already due emerge
    nout = 0;
    frame_px(2 * W + 5, 0);
    rst = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (due_q[i] > cyc) begin exp_q.delete(i); due_q.delete(i); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstpulse_vld", int'(imoy_vld), 0);
    check("rstpulse_imoy", int'(imoy), 0);
    @(posedge clk); #1;
    drain();
    nout = 0;
    frame_px(5 * W, 1);
    drain();
    check("post_rst_count", nout, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
